// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Streams one complex sample per valid cycle. The first half of each
// 2*DELAY frame fills the feedback line. The second half emits a+b and
// pushes a-b into the line. The following frame's fill then drains the
// differences, and each one is tagged with its twiddle exponent.
module r2sdf_bf_stage #(
  parameter int WIDTH = 16,
  parameter int DELAY = 256,
  localparam int KW   = $clog2(DELAY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  output logic signed [WIDTH:0]   out_re,
  output logic signed [WIDTH:0]   out_im,
  output logic                    out_tw_en,
  output logic [KW-1:0]           out_tw_idx,
  output logic                    out_sop
);

  // Sample counter: MSB selects fill/butterfly phase, low bits are k.
  logic [KW:0]   cnt;
  logic          phase;
  logic [KW-1:0] k;
  logic          primed;
  logic          emit;

  assign phase = cnt[KW];
  assign k     = cnt[KW-1:0];

  // The delay line advances exactly once per valid and holds DELAY entries.
  // It is therefore a circular buffer addressed by k. The oldest entry
  // (head) lives at the slot about to be overwritten.
  logic signed [WIDTH:0] mem_re [DELAY];
  logic signed [WIDTH:0] mem_im [DELAY];

  logic signed [WIDTH:0] head_re, head_im;
  logic signed [WIDTH:0] x_re, x_im;
  logic signed [WIDTH:0] sum_re, sum_im;
  logic signed [WIDTH:0] dif_re, dif_im;

  assign head_re = mem_re[k];
  assign head_im = mem_im[k];
  assign x_re    = {in_re[WIDTH-1], in_re};
  assign x_im    = {in_im[WIDTH-1], in_im};

  // Head always started life as a WIDTH-bit input, so WIDTH+1 bits is exact.
  assign sum_re  = head_re + x_re;
  assign sum_im  = head_im + x_im;
  assign dif_re  = head_re - x_re;
  assign dif_im  = head_im - x_im;

  // The first butterfly sample after reset is itself emitted, so it ungates
  // the output in the same cycle that it sets primed.
  assign emit = in_valid & (primed | phase);

  // Delay-line write: raw sample while filling, the difference while butterflying.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      mem_re[k] <= phase ? dif_re : x_re;
      mem_im[k] <= phase ? dif_im : x_im;
    end
  end

  // Counter, primed flag and registered outputs. Data fields hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      primed     <= 1'b0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_tw_en  <= 1'b0;
      out_tw_idx <= '0;
      out_sop    <= 1'b0;
    end else begin
      out_valid <= emit;
      out_sop   <= emit & phase & (k == '0);
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (phase) begin
          primed <= 1'b1;
        end
      end
      if (emit) begin
        out_re     <= phase ? sum_re : head_re;
        out_im     <= phase ? sum_im : head_im;
        out_tw_en  <= ~phase;
        out_tw_idx <= phase ? '0 : k;
      end
    end
  end

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Self-checking bench for r2sdf_bf_stage. Two instances (DELAY=4 and
// DELAY=256) share the same stimulus. Each is checked every cycle against
// a frame-level model built from the history of accepted samples.
module tb_r2sdf_bf_stage;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid;
  logic signed [W-1:0] in_re, in_im;

  logic                v4, tw4, sop4;
  logic signed [W:0]   re4, im4;
  logic [1:0]          idx4;
  logic                v8, tw8, sop8;
  logic signed [W:0]   re8, im8;
  logic [7:0]          idx8;

  r2sdf_bf_stage #(.WIDTH(W), .DELAY(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(v4), .out_re(re4), .out_im(im4), .out_tw_en(tw4),
    .out_tw_idx(idx4), .out_sop(sop4)
  );

  r2sdf_bf_stage #(.WIDTH(W), .DELAY(256)) u_d256 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(v8), .out_re(re8), .out_im(im8), .out_tw_en(tw8),
    .out_tw_idx(idx8), .out_sop(sop8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Accepted-sample history since the last reset.
  int hist_re[$];
  int hist_im[$];

  // Expected output state per instance (0: DELAY=4, 1: DELAY=256).
  bit e_v[2], e_tw[2], e_sop[2];
  int e_re[2], e_im[2], e_idx[2];

  // Valid outputs of the DELAY=4 instance, captured for directed checks.
  int got_re[$];
  int got_im[$];
  int got_idx[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level reference. Sample n is at position p of frame f. In the second
  // half, output a+b with a = the sample D earlier. In the first half of frame
  // f>=1, output a-b of the previous frame's pair at position p.
  task automatic model(input int inst, input int d);
    int n, f, p;
    n = hist_re.size() - 1;
    f = n / (2 * d);
    p = n % (2 * d);
    e_sop[inst] = 1'b0;
    if (p >= d) begin
      e_v[inst]   = 1'b1;
      e_re[inst]  = hist_re[n-d] + hist_re[n];
      e_im[inst]  = hist_im[n-d] + hist_im[n];
      e_tw[inst]  = 1'b0;
      e_idx[inst] = 0;
      e_sop[inst] = (p == d);
    end else if (f >= 1) begin
      e_v[inst]   = 1'b1;
      e_re[inst]  = hist_re[n-2*d] - hist_re[n-d];
      e_im[inst]  = hist_im[n-2*d] - hist_im[n-d];
      e_tw[inst]  = 1'b1;
      e_idx[inst] = p;
    end else begin
      e_v[inst] = 1'b0;
    end
  endtask

  // One clock: drive inputs, advance the model, check both instances after the edge.
  task automatic step(input bit r, input bit v, input int xr, input int xi);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_re    = W'(xr);
    in_im    = W'(xi);
    if (r) begin
      hist_re.delete();
      hist_im.delete();
      for (int i = 0; i < 2; i++) begin
        e_v[i] = 0; e_tw[i] = 0; e_sop[i] = 0;
        e_re[i] = 0; e_im[i] = 0; e_idx[i] = 0;
      end
    end else if (v) begin
      hist_re.push_back(int'(in_re));
      hist_im.push_back(int'(in_im));
      model(0, 4);
      model(1, 256);
    end else begin
      e_v = '{0, 0};
      e_sop = '{0, 0};
    end
    @(posedge clk);
    #1;
    check("d4.valid", v4, e_v[0]);
    check("d4.re", re4, e_re[0]);
    check("d4.im", im4, e_im[0]);
    check("d4.tw_en", tw4, e_tw[0]);
    check("d4.tw_idx", idx4, e_idx[0]);
    check("d4.sop", sop4, e_sop[0]);
    check("d256.valid", v8, e_v[1]);
    check("d256.re", re8, e_re[1]);
    check("d256.im", im8, e_im[1]);
    check("d256.tw_en", tw8, e_tw[1]);
    check("d256.tw_idx", idx8, e_idx[1]);
    check("d256.sop", sop8, e_sop[1]);
    if (v4) begin
      got_re.push_back(int'(re4));
      got_im.push_back(int'(im4));
      got_idx.push_back(int'(idx4));
    end
  endtask

  // Real inputs 1..8 then 8 zeros, optionally with an idle cycle after each.
  task automatic run_ramp(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, (i < 8) ? i + 1 : 0, 0);
      if (gaps) step(0, 0, $urandom_range(0, 65535), $urandom_range(0, 65535));
    end
  endtask

  task automatic check_ramp(input string tag);
    int exp_re[12];
    exp_re = '{6, 8, 10, 12, -4, -4, -4, -4, 0, 0, 0, 0};
    check({tag, ".count"}, got_re.size(), 12);
    if (got_re.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check({tag, ".re"}, got_re[i], exp_re[i]);
        check({tag, ".idx"}, got_idx[i], (i >= 4 && i < 8) ? i - 4 : 0);
      end
    end
    got_re.delete();
    got_im.delete();
    got_idx.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;

    // Reset state.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    got_re.delete(); got_im.delete(); got_idx.delete();

    // Sum then difference.
    run_ramp(0);
    check_ramp("ramp");

    // Valid gaps.
    step(1, 0, 0, 0);
    run_ramp(1);
    check_ramp("gaps");

    // Mid-frame reset, then the clean ramp again.
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 100 + i, -50 - i);
    step(1, 0, 0, 0);
    check("midrst.valid0", v4, 0);
    check("midrst.re0", re4, 0);
    got_re.delete(); got_im.delete(); got_idx.delete();
    run_ramp(0);
    check_ramp("midrst");

    // Extremes on both components.
    step(1, 0, 0, 0);
    step(0, 1, 32767, 32767);
    step(0, 1, -32768, -32768);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, -32768, -32768);
    step(0, 1, 32767, 32767);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    check("ext.count", got_re.size(), 8);
    if (got_re.size() == 8) begin
      check("ext.sum0.re", got_re[0], -1);
      check("ext.sum1.re", got_re[1], -1);
      check("ext.dif0.re", got_re[4], 65535);
      check("ext.dif1.re", got_re[5], -65535);
      check("ext.sum0.im", got_im[0], -1);
      check("ext.dif1.im", got_im[5], -65535);
    end
    got_re.delete(); got_im.delete(); got_idx.delete();

    // Reset/valid collision: the sample is dropped and the counter stays at 0.
    step(0, 1, 7, 7);
    step(1, 1, 1234, 1234);
    check("coll.cnt", u_d4.cnt, 0);
    check("coll.cnt256", u_d256.cnt, 0);
    step(0, 0, 0, 0);
    check("coll.valid", v4, 0);

    // Three back-to-back random frames for DELAY=256, then a flush of zeros.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3 * 512; i++)
      step(0, 1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 256; i++) step(0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
